// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: priority FSM states,
// read-response owner encoding and the width of the debug wait counter.
package dmem_arb_pkg;

    // Which port wins when both request in the same cycle.
    typedef enum logic {
        CPU_PRI = 1'b0,
        DBG_PRI = 1'b1
    } arb_state_e;

    // Port that owns an outstanding read response.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // Width of the consecutive-loss counter; bounds MAX_WAIT to 1..15.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU MEM stage and a
// debug/loader port. The CPU wins contention until the debug port has
// lost MAX_WAIT consecutive cycles; the next contended cycle then goes to
// the debug port. Grants are combinational from the requests and the
// registered priority state. Reads return one cycle after the grant.
//
// Ports
//   clk_i, rst_n                       clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i      CPU request and payload
//   cpu_gnt_o, cpu_stall_o             CPU grant, stall toward hazard logic
//   cpu_rvalid_o, cpu_rdata_o          CPU load response
//   dbg_req_i/we_i/addr_i/wdata_i      debug request and payload
//   dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o   debug grant and response
//   mem_en_o/we_o/addr_o/wdata_o       memory macro command
//   mem_rdata_i                        memory read data (1-cycle latency)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4     // legal range 1..15
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_L = WAIT_W'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_inc;
    logic              rd_pend_q;
    owner_e            rd_owner_q;
    logic              dbg_wins;
    logic              dbg_lost;

    // Grant and memory mux. Grants and stall are gated by rst_n so that
    // nothing reaches the memory while reset is held, even with requests up.
    always_comb begin
        dbg_wins    = dbg_req_i & (~cpu_req_i | (state_q == DBG_PRI));
        dbg_gnt_o   = rst_n & dbg_wins;
        cpu_gnt_o   = rst_n & cpu_req_i & ~dbg_wins;
        cpu_stall_o = rst_n & cpu_req_i & ~cpu_gnt_o;

        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (dbg_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = dbg_we_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
        end else if (cpu_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = cpu_we_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end
    end

    // Wait counter and priority next-state. The counter cannot exceed
    // MAX_WAIT: reaching it flips to DBG_PRI, where a requesting debug port
    // is always granted and the counter clears.
    always_comb begin
        dbg_lost = dbg_req_i & ~dbg_gnt_o;
        wait_inc = wait_q + WAIT_W'(1);
        wait_d   = dbg_lost ? wait_inc : '0;
        state_d  = state_q;
        unique case (state_q)
            CPU_PRI: if (dbg_lost && (wait_inc == MAX_WAIT_L)) state_d = DBG_PRI;
            DBG_PRI: if (dbg_gnt_o || !dbg_req_i)              state_d = CPU_PRI;
            default: state_d = CPU_PRI;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CPU_PRI;
            wait_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rd_pend_q  <= mem_en_o & ~mem_we_o;
            rd_owner_q <= dbg_gnt_o ? OWN_DBG : OWN_CPU;
        end
    end

    // Read data is steered to the owner only; the other port sees zero.
    always_comb begin
        cpu_rvalid_o = rd_pend_q & (rd_owner_q == OWN_CPU);
        dbg_rvalid_o = rd_pend_q & (rd_owner_q == OWN_DBG);
        cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
        dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk_i, rst_n;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic        cpu_gnt_o, cpu_stall_o, cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_gnt_o(cpu_gnt_o), .cpu_stall_o(cpu_stall_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
        .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single-port memory macro with synchronous 1-cycle read.
    logic [31:0] tb_mem [0:255];
    initial for (int i = 0; i < 256; i++) tb_mem[i] = 32'd0;
    initial mem_rdata_i = 32'd0;
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) tb_mem[mem_addr_o[9:2]] <= mem_wdata_o;
            else          mem_rdata_i <= tb_mem[mem_addr_o[9:2]];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Debug is granted when the CPU is idle or when it has already lost
    // MAX_WAIT cycles in a row; otherwise the CPU takes the memory.
    int          streak;
    bit          pend, pend_owner_dbg;
    bit [31:0]   pend_data;
    bit [31:0]   ref_mem [int];
    bit          m_cg, m_dg;

    task automatic model_step(input bit do_check);
        bit [31:0] waddr, wdata;
        bit        we;
        m_dg = dbg_req_i && (!cpu_req_i || streak >= MAX_WAIT);
        m_cg = cpu_req_i && !m_dg;
        we    = m_dg ? dbg_we_i : cpu_we_i;
        waddr = m_dg ? dbg_addr_i : (m_cg ? cpu_addr_i : 32'd0);
        wdata = m_dg ? dbg_wdata_i : (m_cg ? cpu_wdata_i : 32'd0);
        if (do_check) begin
            chk("cpu_gnt", cpu_gnt_o, m_cg);
            chk("dbg_gnt", dbg_gnt_o, m_dg);
            chk("cpu_stall", cpu_stall_o, cpu_req_i && !m_cg);
            chk("mem_en", mem_en_o, m_cg || m_dg);
            chk("mem_we", mem_we_o, (m_cg || m_dg) && we);
            chk("mem_addr", mem_addr_o, waddr);
            chk("mem_wdata", mem_wdata_o, wdata);
            chk("cpu_rvalid", cpu_rvalid_o, pend && !pend_owner_dbg);
            chk("dbg_rvalid", dbg_rvalid_o, pend && pend_owner_dbg);
            if (pend) begin
                chk("cpu_rdata", cpu_rdata_o, pend_owner_dbg ? 32'd0 : pend_data);
                chk("dbg_rdata", dbg_rdata_o, pend_owner_dbg ? pend_data : 32'd0);
            end
        end
        streak = (dbg_req_i && !m_dg) ? streak + 1 : 0;
        pend = 1'b0;
        if (m_cg || m_dg) begin
            if (we) ref_mem[int'(waddr[9:2])] = wdata;
            else begin
                pend           = 1'b1;
                pend_owner_dbg = m_dg;
                pend_data      = ref_mem.exists(int'(waddr[9:2])) ? ref_mem[int'(waddr[9:2])] : 32'd0;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        cr, cw; logic [31:0] ca, cd;
        logic        dr, dw; logic [31:0] da, dd;
        logic        ecg, edg, est, ecv; logic [31:0] ecd;
        logic        edv; logic [31:0] edd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cr, cw, input logic [31:0] ca, cd,
                                input logic dr, dw, input logic [31:0] da, dd,
                                input logic ecg, edg, est, ecv, input logic [31:0] ecd,
                                input logic edv, input logic [31:0] edd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.ecg = ecg; v.edg = edg; v.est = est; v.ecv = ecv; v.ecd = ecd;
        v.edv = edv; v.edd = edd;
        return v;
    endfunction

    task automatic fill_table();
        // CPU-only: store 25 to 8, load 8, response next cycle
        vecs.push_back(mk(1,1,8,25, 0,0,0,0, 1,0,0, 0,0, 0,0));
        vecs.push_back(mk(1,0,8,0,  0,0,0,0, 1,0,0, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0, 0,0,0, 1,25, 0,0));
        // Debug-only: store 7 to 0, load 0
        vecs.push_back(mk(0,0,0,0,  1,1,0,7, 0,1,0, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,  1,0,0,0, 0,1,0, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0, 0,0,0, 0,0, 1,7));
        // Starvation bound: 4 losses then a forced debug win, twice
        vecs.push_back(mk(1,0,8,0,  1,0,0,0, 1,0,0, 0,0, 0,0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,8,0, 1,0,0,0, 1,0,0, 1,25, 0,0));
        vecs.push_back(mk(1,0,8,0,  1,0,0,0, 0,1,1, 1,25, 0,0));
        vecs.push_back(mk(1,0,8,0,  1,0,0,0, 1,0,0, 0,0, 1,7));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,8,0, 1,0,0,0, 1,0,0, 1,25, 0,0));
        vecs.push_back(mk(1,0,8,0,  1,0,0,0, 0,1,1, 1,25, 0,0));
        // Withdraw after 3 losses: counter restarts, 4 more losses needed
        vecs.push_back(mk(1,0,8,0,  0,0,0,0, 1,0,0, 0,0, 1,7));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,8,0, 1,0,0,0, 1,0,0, 1,25, 0,0));
        vecs.push_back(mk(1,0,8,0,  0,0,0,0, 1,0,0, 1,25, 0,0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1,0,8,0, 1,0,0,0, 1,0,0, 1,25, 0,0));
        vecs.push_back(mk(1,0,8,0,  1,0,0,0, 0,1,1, 1,25, 0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0, 0,0,0, 0,0, 1,7));
        // Withdraw in the cycle the force would apply: CPU keeps winning
        vecs.push_back(mk(1,0,8,0,  1,0,0,0, 1,0,0, 0,0, 0,0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1,0,8,0, 1,0,0,0, 1,0,0, 1,25, 0,0));
        vecs.push_back(mk(1,0,8,0,  0,0,0,0, 1,0,0, 1,25, 0,0));
        vecs.push_back(mk(1,0,8,0,  1,0,0,0, 1,0,0, 1,25, 0,0));
        vecs.push_back(mk(0,0,0,0,  0,0,0,0, 0,0,0, 1,25, 0,0));
    endtask

    task automatic set_idle();
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    endtask

    bit c_hold, d_hold;

    initial begin
        streak = 0; pend = 0; pend_owner_dbg = 0; pend_data = 0;
        c_hold = 0; d_hold = 0;
        rst_n = 1'b0;
        set_idle();
        cpu_req_i = 1; dbg_req_i = 1; cpu_addr_i = 32'h10; dbg_addr_i = 32'h20;
        // Reset state: requests present but everything held off
        #2;
        chk("rst_cpu_gnt", cpu_gnt_o, 0);
        chk("rst_dbg_gnt", dbg_gnt_o, 0);
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_rvalid", {cpu_rvalid_o, dbg_rvalid_o}, 0);
        @(posedge clk_i); #1;
        set_idle();
        rst_n = 1'b1;

        fill_table();
        foreach (vecs[i]) begin
            cpu_req_i = vecs[i].cr; cpu_we_i = vecs[i].cw;
            cpu_addr_i = vecs[i].ca; cpu_wdata_i = vecs[i].cd;
            dbg_req_i = vecs[i].dr; dbg_we_i = vecs[i].dw;
            dbg_addr_i = vecs[i].da; dbg_wdata_i = vecs[i].dd;
            @(negedge clk_i);
            chk($sformatf("v%0d_cpu_gnt", i), cpu_gnt_o, vecs[i].ecg);
            chk($sformatf("v%0d_dbg_gnt", i), dbg_gnt_o, vecs[i].edg);
            chk($sformatf("v%0d_stall", i), cpu_stall_o, vecs[i].est);
            chk($sformatf("v%0d_mem_en", i), mem_en_o, vecs[i].ecg | vecs[i].edg);
            chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid_o, vecs[i].ecv);
            chk($sformatf("v%0d_dbg_rvalid", i), dbg_rvalid_o, vecs[i].edv);
            if (vecs[i].ecv || vecs[i].edv) begin
                chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata_o, vecs[i].ecd);
                chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata_o, vecs[i].edd);
            end
            $display("vec %0d: cgnt=%0b dgnt=%0b stall=%0b crv=%0b drv=%0b",
                     i, cpu_gnt_o, dbg_gnt_o, cpu_stall_o, cpu_rvalid_o, dbg_rvalid_o);
            model_step(1'b0);
            @(posedge clk_i); #1;
        end

        // Reset with a granted CPU load in flight
        set_idle();
        cpu_req_i = 1; cpu_addr_i = 8;
        @(negedge clk_i);
        chk("midrd_gnt", cpu_gnt_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midrd_rst_cpu_gnt", cpu_gnt_o, 0);
        chk("midrd_rst_mem_en", mem_en_o, 0);
        chk("midrd_rst_stall", cpu_stall_o, 0);
        streak = 0; pend = 0;
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("midrd_rst_dbg_gnt", dbg_gnt_o, 0);
        set_idle();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("midrd_cpu_rvalid", cpu_rvalid_o, 0);
            chk("midrd_dbg_rvalid", dbg_rvalid_o, 0);
            $display("post-reset cycle %0d: crv=%0b drv=%0b", k, cpu_rvalid_o, dbg_rvalid_o);
            model_step(1'b0);
            @(posedge clk_i); #1;
        end

        // Random traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!c_hold) begin
                cpu_req_i   = ($urandom_range(0, 9) < 6);
                cpu_we_i    = 1'($urandom_range(0, 1));
                cpu_addr_i  = 32'($urandom_range(0, 15)) << 2;
                cpu_wdata_i = $urandom;
            end
            if (!d_hold) begin
                dbg_req_i   = ($urandom_range(0, 9) < 5);
                dbg_we_i    = 1'($urandom_range(0, 1));
                dbg_addr_i  = 32'($urandom_range(0, 15)) << 2;
                dbg_wdata_i = $urandom;
            end
            @(negedge clk_i);
            model_step(1'b1);
            if (cyc % 250 == 0)
                $display("rand %0d: creq=%0b dreq=%0b cgnt=%0b dgnt=%0b", cyc,
                         cpu_req_i, dbg_req_i, cpu_gnt_o, dbg_gnt_o);
            c_hold = cpu_req_i && !m_cg;
            d_hold = dbg_req_i && !m_dg;
            @(posedge clk_i); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory of `Pipe_CPU` between the MEM stage of the pipeline and a debug/loader port used for preloading and dumping memory during simulation and bring-up. Arbitration is CPU-first with a bounded-wait guarantee for the debug port. When the CPU loses arbitration, the block raises a stall toward the hazard logic. Sits between the EX/MEM pipeline register and the data memory macro, which has a synchronous 1-cycle read.

## Interface
- `ADDR_W`, default 32, byte address width on all ports.
- `DATA_W`, default 32, data width.
- `MAX_WAIT`, default 4, consecutive lost cycles after which the debug port is forced to win. Legal range is 1..15.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req_i`  in  1  MEM-stage access request (MemRead | MemWrite).
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  ADDR_W  access address.
- `cpu_wdata_i`  in  DATA_W  store data.
- `cpu_gnt_o`  out  1  request accepted this cycle.
- `cpu_stall_o`  out  1  `cpu_req_i & ~cpu_gnt_o`; freezes PC, IF/ID, ID/EX and EX/MEM.
- `cpu_rvalid_o`  out  1  load data valid.
- `cpu_rdata_o`  out  DATA_W  load data.
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i`  in  1/1/ADDR_W/DATA_W  debug request; same meaning as the cpu_* inputs.
- `dbg_gnt_o`, `dbg_rvalid_o`, `dbg_rdata_o`  out  1/1/DATA_W  debug grant and response.
- `mem_en_o`  out  1  memory access enable.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_wdata_o`  out  DATA_W  memory write data.
- `mem_rdata_i`  in  DATA_W  read data; valid the cycle after a read enable.

## Operation
- Request/grant protocol:
  - A requester holds its req and payload stable until it sees gnt.
  - gnt is combinational from the current req inputs and the registered state.
  - At most one gnt per cycle.
- Priority FSM, two states:
  - CPU_PRI (reset state): CPU wins when both ports request.
  - DBG_PRI: debug wins when both ports request.
- Wait counter `wait_q` (4 bits):
  - Increments in a cycle where dbg_req=1 and dbg_gnt=0.
  - Clears on any dbg_gnt, or when dbg_req=0.
- FSM transitions:
  - CPU_PRI→DBG_PRI on the edge where the incremented `wait_q` equals MAX_WAIT.
  - DBG_PRI→CPU_PRI on the edge after any dbg_gnt.
  - In DBG_PRI with dbg_req=0 (request withdrawn), return to CPU_PRI.
- A sole requester is always granted, regardless of FSM state.
- Memory port mux:
  - mem_* signals carry the winner's payload, with mem_en_o = 1.
  - With no grant: mem_en_o=0, mem_we_o=0, and addr/wdata driven to 0.
- Response tracking uses registers `rd_pend_q` and `rd_owner_q`:
  - They are set on a granted read.
  - Next cycle, the owner's rvalid=1 and its rdata = mem_rdata_i.
  - The other port's rdata is 0.
  - Writes produce no rvalid.

## Timing
- Grant latency: 0 cycles (same cycle as req, when the port wins).
- Read latency: rvalid exactly 1 cycle after gnt. Back-to-back reads give a response every cycle.
- Write takes effect at the memory on the grant-cycle edge.
- Worst-case debug wait: MAX_WAIT cycles of loss, then a guaranteed grant on the next cycle. The CPU stalls for exactly 1 cycle per forced debug win.
- Reset values (asynchronous, immediate):
  - FSM = CPU_PRI, wait_q = 0, rd_pend_q = 0.
  - All gnt/rvalid/stall outputs = 0 while rst_n = 0.
  - mem_en_o = 0, all data outputs = 0.
- Reset asserted with a read in flight: the response is dropped, and no rvalid is issued after release.
- A debug req withdrawn in the same cycle the force would apply: no grant, counter = 0, FSM = CPU_PRI.
- Simultaneous CPU store and debug load to the same address in consecutive cycles: ordering equals grant order; no forwarding inside the block.

## Structure
- Shared package `dmem_arb_pkg`:
  - FSM state enum (CPU_PRI, DBG_PRI).
  - Owner encoding (OWN_CPU=0, OWN_DBG=1).
  - WAIT_W = 4.
- Single module; no sub-module required.
- The grant/mux logic is combinational; the FSM, wait counter and response tracking are registered.

## Test plan
- CPU-only traffic:
  - Stimulus: CPU store 25 to addr 8, then load addr 8.
  - Response: gnt both cycles, stall=0, rvalid one cycle after the load grant with rdata=25.
- Debug-only traffic:
  - Stimulus: debug store 7 to addr 0, then load addr 0.
  - Response: dbg_gnt immediate, dbg_rvalid=1 with dbg_rdata=7; cpu_rvalid stays 0.
- Starvation bound:
  - Stimulus: CPU and debug requesting continuously with MAX_WAIT=4.
  - Response: debug loses 4 cycles, wins cycle 5, and cpu_stall_o=1 in exactly that cycle; the pattern repeats every 5 cycles.
- Withdraw:
  - Stimulus: dbg_req held for 3 lost cycles, then dropped.
  - Response: wait_q=0, FSM stays CPU_PRI, no spurious dbg_gnt.
- Reset mid-read:
  - Stimulus: CPU load granted, then rst_n=0 before the next edge.
  - Response: no cpu_rvalid after release; mem_en_o=0 and all grants 0 during reset.
- Pipeline integration:
  - Stimulus: run `Pipe_CPU` with a debug dump of m0..m15 issued during execution.
  - Response: final registers and memory match a run without debug traffic; the cycle count grows by exactly the number of forced debug wins.
